mips_multicycle_ctrl: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback,

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/mips_mc_outdec.sv | 72 +++++++
 rtl/mips_multicycle_ctrl.sv | 133 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the multicycle MIPS control path:
//   opcode values, ALUOp encodings, mux select codes, the control-FSM state
//   encoding and the packed bundle of control strobes.
//   The state encoding carries the ADDI states unconditionally, so it is the
//   same whether or not MIPS_MC_ADDI_EN is defined.
// -----------------------------------------------------------------------------
package mips_pkg;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALUOp to ALUControl
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ALU B-input mux
    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// -----------------------------------------------------------------------------
// mips_mc_outdec
//   Pure combinational decode of the control-FSM state into datapath strobes.
//   Ports:
//     state      in   current FSM state
//     mem_ready  in   gates ir_write/pc_write in FETCH (only commit once the
//                     instruction word has actually arrived)
//     ctrl       out  control strobe bundle
// -----------------------------------------------------------------------------
module mips_mc_outdec
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a strobe unassigned, which would infer a latch.
        ctrl           = '0;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.alu_src_b = ALUB_REG;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = ALUB_FOUR;
            end
            S_DECODE: ctrl.alu_src_b = ALUB_IMM_SH2;   // precompute branch target
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Main control FSM for the multicycle MIPS datapath. Sequences
//   fetch/decode/execute/memory/writeback and drives every mux/enable strobe.
//   Memory states stall on mem_ready; a stall counter turns a hung access
//   into a sticky mem_err. Unknown opcodes set a sticky illegal_op and are
//   retired as nops.
//
//   Parameter MEM_TIMEOUT: number of consecutive not-ready cycles tolerated
//     in one memory state. A further not-ready cycle, found with the counter
//     already at MEM_TIMEOUT, aborts the access to FETCH and sets mem_err;
//     mem_ready in that cycle still completes normally. 0 disables it.
//   Macro MIPS_MC_ADDI_EN: when defined, opcode 6'h08 (addi) is executed via
//     ADDIEX/ADDIWB; otherwise it is illegal.
//
//   Ports: clk, rst_n (synchronous, active low), opcode (IR[31:26]),
//     mem_ready; strobes pc_write, pc_write_cond, i_or_d, mem_read,
//     mem_write, ir_write, mem_to_reg, pc_source, alu_op, alu_src_a,
//     alu_src_b, reg_write, reg_dst; sticky flags illegal_op, mem_err.
//   All strobes are forced to 0 while rst_n is low.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       illegal_op,
    output logic       mem_err
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic       TIMEOUT_EN  = (MEM_TIMEOUT != 0);

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic       waiting, timeout, set_illegal;
    ctrl_t      ctrl, ctrl_gated;

    assign waiting = is_mem_state(state) && !mem_ready;
    assign timeout = waiting && TIMEOUT_EN && (wait_cnt == TIMEOUT_LIM);

    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        unique case (state)
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
                    OP_ADDI:      next_state = S_ADDIEX;
`endif
                    default: begin
                        next_state  = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH;
            S_EXEC:   next_state = S_RWB;
            S_ADDIEX: next_state = S_ADDIWB;
            default:  next_state = S_FETCH;   // single-cycle tail states
        endcase
        // A timed-out access is dropped and fetch restarts.
        if (timeout) next_state = S_FETCH;
    end

    always_ff @(posedge clk) begin
        // NOTE: reset only clears architectural control state; everything
        // here is sequential, so non-blocking assignments throughout.
        if (!rst_n) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state <= next_state;
            // Counter only runs while a memory state is stalled; any exit
            // (completion or timeout) returns it to zero.
            if (waiting && !timeout) wait_cnt <= wait_cnt + 8'd1;
            else                     wait_cnt <= '0;
            if (set_illegal) illegal_op <= 1'b1;
            if (timeout)     mem_err    <= 1'b1;
        end
    end

    mips_mc_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Strobes are held off combinationally during reset so an abandoned
    // instruction cannot write anything in the reset cycle.
    assign ctrl_gated = rst_n ? ctrl : '0;

    assign pc_write      = ctrl_gated.pc_write;
    assign pc_write_cond = ctrl_gated.pc_write_cond;
    assign i_or_d        = ctrl_gated.i_or_d;
    assign mem_read      = ctrl_gated.mem_read;
    assign mem_write     = ctrl_gated.mem_write;
    assign ir_write      = ctrl_gated.ir_write;
    assign mem_to_reg    = ctrl_gated.mem_to_reg;
    assign pc_source     = ctrl_gated.pc_source;
    assign alu_op        = ctrl_gated.alu_op;
    assign alu_src_a     = ctrl_gated.alu_src_a;
    assign alu_src_b     = ctrl_gated.alu_src_b;
    assign reg_write     = ctrl_gated.reg_write;
    assign reg_dst       = ctrl_gated.reg_dst;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Self-checking bench for mips_multicycle_ctrl (MEM_TIMEOUT=4). The
//   reference model walks each instruction through its list of phases as
//   written in the instruction-set description, choosing memory stall lengths
//   at random and predicting strobes, flags and timeouts every cycle.
//   Follows MIPS_MC_ADDI_EN for opcode 6'h08.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int TO = 4;

    localparam logic [5:0] R_OP   = 6'h00;
    localparam logic [5:0] LW_OP  = 6'h23;
    localparam logic [5:0] SW_OP  = 6'h2B;
    localparam logic [5:0] BEQ_OP = 6'h04;
    localparam logic [5:0] J_OP   = 6'h02;
    localparam logic [5:0] ADDI_OP = 6'h08;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXEC, P_RWB, P_BRANCH, P_JUMP, P_ADDIEX, P_ADDIWB} phase_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, alu_src_a, reg_write, reg_dst, illegal_op, mem_err;
    logic [1:0] pc_source, alu_op, alu_src_b;

    int errors = 0;
    int checks = 0;
    bit exp_ill = 1'b0;
    bit exp_err = 1'b0;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .illegal_op    (illegal_op),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    // 16 strobe bits followed by the two sticky flags
    wire [17:0] obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_write, reg_dst, alu_src_a, pc_source, alu_op,
                       alu_src_b, illegal_op, mem_err};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pack(
        input bit pw, input bit pwc, input bit iod, input bit mr, input bit mw,
        input bit irw, input bit m2r, input bit rw, input bit rd, input bit asa,
        input logic [1:0] ps, input logic [1:0] ao, input logic [1:0] asb);
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, ps, ao, asb};
    endfunction

    // Expected strobes for each phase of an instruction.
    function automatic logic [15:0] exp_vec(input phase_t p, input bit rdy);
        case (p)
            //                     pw  pwc iod mr mw irw m2r rw rd asa ps     ao     asb
            P_FETCH:  return pack(rdy, 0, 0,  1, 0, rdy, 0,  0, 0, 0, 2'b00, 2'b00, 2'b01);
            P_DECODE: return pack(0,   0, 0,  0, 0, 0,   0,  0, 0, 0, 2'b00, 2'b00, 2'b11);
            P_MEMADR: return pack(0,   0, 0,  0, 0, 0,   0,  0, 0, 1, 2'b00, 2'b00, 2'b10);
            P_MEMRD:  return pack(0,   0, 1,  1, 0, 0,   0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
            P_MEMWB:  return pack(0,   0, 0,  0, 0, 0,   1,  1, 0, 0, 2'b00, 2'b00, 2'b00);
            P_MEMWR:  return pack(0,   0, 1,  0, 1, 0,   0,  0, 0, 0, 2'b00, 2'b00, 2'b00);
            P_EXEC:   return pack(0,   0, 0,  0, 0, 0,   0,  0, 0, 1, 2'b00, 2'b10, 2'b00);
            P_RWB:    return pack(0,   0, 0,  0, 0, 0,   0,  1, 1, 0, 2'b00, 2'b00, 2'b00);
            P_BRANCH: return pack(0,   1, 0,  0, 0, 0,   0,  0, 0, 1, 2'b01, 2'b01, 2'b00);
            P_JUMP:   return pack(1,   0, 0,  0, 0, 0,   0,  0, 0, 0, 2'b10, 2'b00, 2'b00);
            P_ADDIEX: return pack(0,   0, 0,  0, 0, 0,   0,  0, 0, 1, 2'b00, 2'b00, 2'b10);
            P_ADDIWB: return pack(0,   0, 0,  0, 0, 0,   0,  1, 0, 0, 2'b00, 2'b00, 2'b00);
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic logic [5:0] noise();
        return 6'($urandom);
    endfunction

    // One clock cycle: drive inputs after the falling edge, check mid-low-phase.
    task automatic step(input string tag, input phase_t p, input logic [5:0] op, input bit rdy);
        @(negedge clk);
        rst_n     = 1'b1;
        opcode    = op;
        mem_ready = rdy;
        #1;
        check(tag, obs, {exp_vec(p, rdy), exp_ill, exp_err});
    endtask

    // A memory phase stalled for 'waits' cycles. More than TO stalls means
    // TO+1 not-ready cycles followed by an abort with mem_err.
    task automatic mem_step(input phase_t p, input int waits, output bit tmo);
        int lows;
        lows = (waits > TO) ? TO + 1 : waits;
        for (int i = 0; i < lows; i++)
            step({p.name(), "_stall"}, p, noise(), 1'b0);
        if (waits > TO) begin
            tmo     = 1'b1;
            exp_err = 1'b1;
        end else begin
            tmo = 1'b0;
            step(p.name(), p, noise(), 1'b1);
        end
    endtask

    // Run one instruction; negative wait counts are randomised (0..6).
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        bit tmo;
        int tries;
        int w;
        tries = 0;
        w = (fw < 0) ? int'($urandom_range(0, 6)) : fw;
        do begin
            mem_step(P_FETCH, w, tmo);
            w = int'($urandom_range(0, TO));
            tries++;
        end while (tmo && tries < 20);
        w = (mw < 0) ? int'($urandom_range(0, 6)) : mw;
        step("DECODE", P_DECODE, op, 1'($urandom));
        case (op)
            LW_OP: begin
                step("MEMADR", P_MEMADR, op, 1'($urandom));
                mem_step(P_MEMRD, w, tmo);
                if (!tmo) step("MEMWB", P_MEMWB, noise(), 1'($urandom));
            end
            SW_OP: begin
                step("MEMADR", P_MEMADR, op, 1'($urandom));
                mem_step(P_MEMWR, w, tmo);
            end
            R_OP: begin
                step("EXEC", P_EXEC, noise(), 1'($urandom));
                step("RWB", P_RWB, noise(), 1'($urandom));
            end
            BEQ_OP: step("BRANCH", P_BRANCH, noise(), 1'($urandom));
            J_OP:   step("JUMP", P_JUMP, noise(), 1'($urandom));
`ifdef MIPS_MC_ADDI_EN
            ADDI_OP: begin
                step("ADDIEX", P_ADDIEX, noise(), 1'($urandom));
                step("ADDIWB", P_ADDIWB, noise(), 1'($urandom));
            end
`endif
            default: exp_ill = 1'b1;   // retired as a nop, flag visible next cycle
        endcase
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] pool [7];
        pool[0] = R_OP; pool[1] = LW_OP; pool[2] = SW_OP; pool[3] = BEQ_OP;
        pool[4] = J_OP; pool[5] = ADDI_OP; pool[6] = noise();
        return pool[$urandom_range(0, 6)];
    endfunction

    initial begin
        bit tmo;

        // Power-on reset, two cycles
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk); #1;
        check("reset_c1", obs, 18'h0);
        @(negedge clk); #1;
        check("reset_c2", obs, 18'h0);

        // Directed cases
        run_instr(R_OP,    0, 0);   // 4-cycle R-type
        run_instr(LW_OP,   0, 3);   // MEMRD stalled 3 cycles
        run_instr(BEQ_OP,  0, 0);
        run_instr(6'h3F,   0, 0);   // illegal, flag must stick
        run_instr(R_OP,    0, 0);
        run_instr(SW_OP,   0, TO);  // ready arrives exactly at the limit
        run_instr(J_OP,    6, 0);   // fetch times out, then restarts
        run_instr(ADDI_OP, 0, 0);
        run_instr(LW_OP,   0, 6);   // MEMRD times out

        // Reset mid-lw while MEMRD is stalled, flags already set
        mem_step(P_FETCH, 0, tmo);
        step("DECODE", P_DECODE, LW_OP, 1'b1);
        step("MEMADR", P_MEMADR, LW_OP, 1'b1);
        step("MEMRD_stall", P_MEMRD, noise(), 1'b0);
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1; opcode = noise();
        #1;
        check("midrst_strobes", {obs[17:2], 2'b00}, 18'h0);
        @(negedge clk); #1;
        check("midrst_all", obs, 18'h0);
        exp_ill = 1'b0;
        exp_err = 1'b0;
        run_instr(R_OP, 0, 0);      // must start cleanly from FETCH

        // Randomised instruction stream
        for (int n = 0; n < 300; n++)
            run_instr(pick_op(), -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net: the stimulus is bounded, so this never fires on a sane run.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
